// File: rtl/vector_lane_memory.sv
// Lane-serial vector load/store unit: one vector request is serviced one lane per cycle
// against a single narrow synchronous memory while the pipeline is stalled.
module vector_lane_memory #(
    parameter int LANES  = 4,
    parameter int LANE_W = 8,
    parameter int ADDR_W = 10,
    parameter int OFF_W  = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RE,
    input  logic                      WE,
    input  logic                      MODE,
    input  logic [LANES-1:0]          MASK,
    input  logic [ADDR_W-1:0]         BA,
    input  logic [LANES*OFF_W-1:0]    VO,
    input  logic [LANES*LANE_W-1:0]   WD,
    output logic                      SP,
    output logic                      RV,
    output logic [LANES*LANE_W-1:0]   RD
);

    localparam int CNT_W = $clog2(LANES);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                    state_r;
    state_t                    state_s;
    logic [CNT_W-1:0]          cnt_r;
    logic [ADDR_W-1:0]         base_r;
    logic [ADDR_W-1:0]         addr_r;
    logic [LANES*OFF_W-1:0]    vo_r;
    logic [LANES*LANE_W-1:0]   wd_r;
    logic [LANES-1:0]          mask_r;
    logic                      mode_r;
    logic                      wr_r;
    logic                      pend_r;
    logic [CNT_W-1:0]          pend_lane_r;
    logic                      pend_en_r;
    logic [LANE_W-1:0]         mem_q_r;
    logic [LANES*LANE_W-1:0]   buf_r;
    logic [LANES*LANE_W-1:0]   buf_s;
    logic [LANES*LANE_W-1:0]   rd_r;
    logic                      rv_r;
    logic                      accept_s;
    logic                      last_s;
    logic                      sp_s;
    logic                      mem_we_s;
    logic [OFF_W-1:0]          off_s;
    logic [ADDR_W-1:0]         lane_addr_s;
    logic [LANE_W-1:0]         mem [DEPTH];

    assign accept_s = ((state_r == IDLE) || (state_r == DONE)) && (RE || WE);
    assign last_s   = (cnt_r == LAST_LANE);
    assign off_s    = vo_r[cnt_r*OFF_W +: OFF_W];
    assign mem_we_s = !RST && (state_r == ACCESS) && wr_r && mask_r[cnt_r];
    assign SP       = sp_s;
    assign RV       = rv_r;
    assign RD       = rd_r;

    // Lane address: strided mode uses the running sum, gather adds the lane offset to the base.
    always_comb begin
        lane_addr_s = base_r;
        if (mode_r) begin
            lane_addr_s = addr_r;
        end else begin
            lane_addr_s = base_r + ADDR_W'(off_s);
        end
    end

    // Pipeline stall: held through the whole request, released in DONE unless a new one arrives.
    always_comb begin
        sp_s = 1'b0;
        if (RST) begin
            sp_s = 1'b0;
        end else if ((state_r == ACCESS) || (state_r == DRAIN)) begin
            sp_s = 1'b1;
        end else begin
            sp_s = accept_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = accept_s ? ACCESS : IDLE;
            ACCESS: begin
                if (last_s) begin
                    state_s = wr_r ? DONE : DRAIN;
                end else begin
                    state_s = ACCESS;
                end
            end
            DRAIN:   state_s = DONE;
            DONE:    state_s = accept_s ? ACCESS : IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Read-return merge: the word fetched last cycle lands in its lane, masked lanes read as zero.
    always_comb begin
        buf_s = buf_r;
        if (pend_r) begin
            buf_s[pend_lane_r*LANE_W +: LANE_W] = pend_en_r ? mem_q_r : {LANE_W{1'b0}};
        end else begin
            buf_s = buf_r;
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request latch, lane counter, strided running address and read-return tracking.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_r       <= '0;
            base_r      <= '0;
            addr_r      <= '0;
            vo_r        <= '0;
            wd_r        <= '0;
            mask_r      <= '0;
            mode_r      <= 1'b0;
            wr_r        <= 1'b0;
            pend_r      <= 1'b0;
            pend_lane_r <= '0;
            pend_en_r   <= 1'b0;
            buf_r       <= '0;
            rd_r        <= '0;
            rv_r        <= 1'b0;
        end else begin
            pend_r      <= (state_r == ACCESS) && !wr_r;
            pend_lane_r <= cnt_r;
            pend_en_r   <= mask_r[cnt_r];
            buf_r       <= buf_s;
            rv_r        <= (state_r == DRAIN);
            if (state_r == DRAIN) begin
                rd_r <= buf_s;
            end
            if (accept_s) begin
                cnt_r  <= '0;
                base_r <= BA;
                addr_r <= BA;
                vo_r   <= VO;
                wd_r   <= WD;
                mask_r <= MASK;
                mode_r <= MODE;
                wr_r   <= WE;
            end else if (state_r == ACCESS) begin
                cnt_r  <= last_s ? '0 : cnt_r + CNT_W'(1);
                addr_r <= addr_r + ADDR_W'(vo_r[OFF_W-1:0]);
            end
        end
    end

    // Single-port storage with one-cycle read latency; contents survive reset.
    always_ff @(posedge CLK) begin
        if (mem_we_s) begin
            mem[lane_addr_s] <= wd_r[cnt_r*LANE_W +: LANE_W];
        end
        mem_q_r <= mem[lane_addr_s];
    end

endmodule

// File: tb/tb_vector_lane_memory.sv
// Directed bench for vector_lane_memory: a byte-level memory model predicts read results,
// which queue in a scoreboard and are popped when RV pulses.
module tb_vector_lane_memory;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        RE = 1'b0;
    logic        WE = 1'b0;
    logic        MODE = 1'b0;
    logic [3:0]  MASK = 4'h0;
    logic [9:0]  BA = 10'h000;
    logic [31:0] VO = 32'h0;
    logic [31:0] WD = 32'h0;
    logic        SP;
    logic        RV;
    logic [31:0] RD;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [7:0]  mdl [1024];
    logic [31:0] sb_q [$];

    vector_lane_memory #(.LANES(4), .LANE_W(8), .ADDR_W(10), .OFF_W(8)) dut (
        .CLK(CLK), .RST(RST), .RE(RE), .WE(WE), .MODE(MODE), .MASK(MASK),
        .BA(BA), .VO(VO), .WD(WD), .SP(SP), .RV(RV), .RD(RD)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] lane_addr(input logic m, input logic [9:0] ba,
                                             input logic [31:0] vo, input int k);
        if (m) return ba + 10'(k * int'(vo[7:0]));
        return ba + {2'b00, vo[k*8 +: 8]};
    endfunction

    // Drives one request at the current negedge and checks every cycle through DONE.
    task automatic req(input logic w, input logic r, input logic m, input logic [3:0] mk,
                       input logic [9:0] ba, input logic [31:0] vo, input logic [31:0] wd,
                       input bit chain);
        int done_cyc;
        logic [31:0] e;
        logic [31:0] got;
        WE = w; RE = r; MODE = m; MASK = mk; BA = ba; VO = vo; WD = wd;
        e = 32'h0;
        if (w) begin
            for (int k = 0; k < 4; k++)
                if (mk[k]) mdl[lane_addr(m, ba, vo, k)] = wd[k*8 +: 8];
            done_cyc = 5;
        end else begin
            for (int k = 0; k < 4; k++)
                e[k*8 +: 8] = mk[k] ? mdl[lane_addr(m, ba, vo, k)] : 8'h00;
            sb_q.push_back(e);
            done_cyc = 6;
        end
        for (int c = 0; c <= done_cyc; c++) begin
            if (c > 0) @(negedge CLK);
            if (c == 2) begin
                BA = ~ba; VO = ~vo; WD = ~wd; MASK = ~mk; MODE = ~m;
            end
            if (c == done_cyc && !chain) begin
                WE = 1'b0; RE = 1'b0;
            end
            #1;
            chk("sp", 32'(SP), 32'(c < done_cyc || chain));
            if (c > 0) chk("rv", 32'(RV), 32'(!w && c == done_cyc));
            if (RV && c > 0) begin
                if (sb_q.size() == 0) begin
                    chk("sb_empty", 32'(sb_q.size()), 32'd1);
                end else begin
                    got = sb_q.pop_front();
                    chk("rd", RD, got);
                end
            end
        end
    endtask

    initial begin
        @(negedge CLK);
        #1;
        chk("rst_sp", 32'(SP), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("rst_rv", 32'(RV), 32'd0);
        chk("rst_rd", RD, 32'h0);
        chk("rst_sp_idle", 32'(SP), 32'd0);

        // scatter write and gather read
        req(1'b1, 1'b0, 1'b0, 4'hF, 10'h100, 32'h03020100, 32'hDDCCBBAA, 1'b0);
        req(1'b0, 1'b1, 1'b0, 4'hF, 10'h100, 32'h03020100, 32'h0, 1'b0);
        chk("rd_scatter", RD, 32'hDDCCBBAA);

        // masked write, full read, masked read
        req(1'b1, 1'b0, 1'b0, 4'h5, 10'h100, 32'h03020100, 32'h44332211, 1'b0);
        req(1'b0, 1'b1, 1'b0, 4'hF, 10'h100, 32'h03020100, 32'h0, 1'b0);
        chk("rd_mwrite", RD, 32'hDD33BB11);
        req(1'b0, 1'b1, 1'b0, 4'hA, 10'h100, 32'h03020100, 32'h0, 1'b0);
        chk("rd_mread", RD, 32'hDD00BB00);

        // strided write with wrap; upper offset fields must be ignored
        req(1'b1, 1'b0, 1'b1, 4'hF, 10'h3FE, 32'hFFEEDD03, 32'h04030201, 1'b0);
        req(1'b0, 1'b1, 1'b0, 4'hF, 10'h3FE, 32'h09060300, 32'h0, 1'b0);
        chk("rd_stride", RD, 32'h04030201);
        req(1'b0, 1'b1, 1'b1, 4'hF, 10'h3FE, 32'h00000003, 32'h0, 1'b0);

        // WE and RE together execute a write; RD keeps the previous read value
        req(1'b1, 1'b1, 1'b0, 4'hF, 10'h200, 32'h03020100, 32'h0D0C0B0A, 1'b0);
        chk("rd_hold", RD, 32'h04030201);
        req(1'b0, 1'b1, 1'b0, 4'hF, 10'h200, 32'h03020100, 32'h0, 1'b0);

        // duplicate addresses: highest lane wins
        req(1'b1, 1'b0, 1'b0, 4'hF, 10'h220, 32'h00000000, 32'h44332211, 1'b0);
        req(1'b0, 1'b1, 1'b0, 4'h1, 10'h220, 32'h00000000, 32'h0, 1'b0);
        chk("rd_dup", RD, 32'h00000044);

        // back-to-back: read accepted in the write's DONE cycle
        req(1'b1, 1'b0, 1'b0, 4'hF, 10'h210, 32'h00010203, 32'hA5B6C7D8, 1'b1);
        req(1'b0, 1'b1, 1'b0, 4'hF, 10'h210, 32'h00010203, 32'h0, 1'b0);
        chk("rd_b2b", RD, 32'hA5B6C7D8);

        // reset in the middle of a write
        req(1'b1, 1'b0, 1'b0, 4'hF, 10'h300, 32'h03020100, 32'h55555555, 1'b0);
        WE = 1'b1; MODE = 1'b0; MASK = 4'hF; BA = 10'h300; VO = 32'h03020100; WD = 32'hDDCCBBAA;
        #1;
        chk("mid_sp0", 32'(SP), 32'd1);
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1; WE = 1'b0;
        #1;
        chk("mid_sp_rst", 32'(SP), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("mid_sp", 32'(SP), 32'd0);
        chk("mid_rv", 32'(RV), 32'd0);
        chk("mid_rd", RD, 32'h0);
        mdl[10'h300] = 8'hAA;
        mdl[10'h301] = 8'hBB;
        req(1'b0, 1'b1, 1'b0, 4'hF, 10'h300, 32'h03020100, 32'h0, 1'b0);
        chk("rd_mid", RD, 32'h5555BBAA);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vector_lane_memory.md
# vector_lane_memory

Parametrised lane-serial vector load/store unit for the vector datapath's memory stage. It accepts one vector read or write per request, accesses a single narrow internal memory one lane per cycle, and stalls the pipeline for the duration. Beyond the fixed 4×8-bit byte-serial access, it adds configurable lane count and width, per-lane write/read masking, a strided addressing mode alongside gather/scatter offsets, and an explicit read-valid strobe.

## Interface
- LANES, 4, number of vector lanes (≥2)
- LANE_W, 8, bits per lane / memory word width
- ADDR_W, 10, memory address width; depth = 2^ADDR_W words
- OFF_W, 8, per-lane offset / stride width (OFF_W ≤ ADDR_W)

- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- RE  in  1  vector read request
- WE  in  1  vector write request (priority over RE if both high)
- MODE  in  1  0 = gather/scatter (per-lane offsets), 1 = strided
- MASK  in  LANES  lane enable; bit i gates lane i
- BA  in  ADDR_W  base address
- VO  in  LANES*OFF_W  lane i offset at [i*OFF_W +: OFF_W]; in strided mode only lane 0 field is used, as stride
- WD  in  LANES*LANE_W  write data, lane i at [i*LANE_W +: LANE_W]
- SP  out  1  stop pipeline
- RV  out  1  read data valid, one-cycle pulse
- RD  out  LANES*LANE_W  read data, lane i at [i*LANE_W +: LANE_W]

## Operation
- States: IDLE, ACCESS, DRAIN, DONE. Accepting states: IDLE and DONE.
- Accept: in an accepting state with RE|WE=1, latch BA, VO, WD, MASK, MODE, and op type (write if WE, else read). Lane counter goes to 0. Go to ACCESS.
- ACCESS: each cycle services lane k = counter, for k = 0..LANES-1.
  - Address, gather mode: BA + zero-extend(VO lane k).
  - Address, strided mode: BA + k*stride, computed as a running sum.
  - All address arithmetic is modulo 2^ADDR_W (wraps).
- Write lane k: the memory word is written with WD lane k only if MASK[k]=1; masked lanes leave memory untouched.
- Read lane k: synchronous memory read with 1-cycle latency. The returned word is captured into lane k of an internal buffer; lanes with MASK[k]=0 capture 0.
- Exit ACCESS after lane LANES-1:
  - write → DONE;
  - read → DRAIN (captures the final lane) → DONE.
- DONE:
  - read: RD is updated from the buffer and RV=1;
  - write: RV=0.
  - Next state: accept if a request is present, else IDLE.
- RD holds its value until the next read completes; writes never alter RD.
- Duplicate addresses in one write: the higher lane wins, since it is written later. A read of an address written earlier in the same write request is not possible; requests are serial.
- Reset (any state, including mid-operation): state=IDLE, counter=0, SP=0, RV=0, RD=0. Lane writes already committed stay in memory; remaining lanes are dropped. Memory contents are not cleared.

## Timing
- Cycle 0 is the accept cycle.
- Write: lanes written at cycles 1..LANES; DONE at cycle LANES+1.
- Read: lane k addressed at cycle k+1 and data captured at cycle k+2; DRAIN at LANES+1; DONE with RV=1 and RD valid at cycle LANES+2.
- SP is combinational:
  - SP=1 in an accepting state when RE|WE=1;
  - SP=1 in ACCESS and DRAIN;
  - SP=0 in DONE when no new request is present, and whenever RST=1.
- The pipeline must hold RE/WE/operands while SP=1. Inputs are sampled only on accept cycles; changes during ACCESS/DRAIN are ignored.
- Back-to-back: a request present in DONE is accepted in that same cycle with no IDLE gap, and SP stays 1.
- With LANES=4: write occupancy is 5 cycles; read occupancy is 6 cycles to RV.

## Test plan
- Scatter write: BA=0x100, VO lanes {0,1,2,3}, WD=0xDDCCBBAA, MASK=1111. Then a gather read with the same operands → RV at cycle 6, RD=0xDDCCBBAA. SP high in cycles 0-4 of the write and cycles 0-5 of the read.
- Masked write: WD=0x44332211, MASK=0101 over the previous data, then full read → RD=0xDDCC33AA? No: lane0=0x11, lane2=0x33 → RD=0xDD33BB11. A read with MASK=1010 → RD=0xDD00BB00.
- Strided and wrap: MODE=1, BA=0x3FE, stride=3, write 0x04030201 → words at 0x3FE, 0x001, 0x004, 0x007. Gather read of those addresses → RD=0x04030201.
- WE and RE both high: executes a write. RV never pulses; DONE is reached at cycle 5.
- Back-to-back: a read request held through DONE of a prior write is accepted in DONE. SP never drops; RV arrives 6 cycles after that DONE.
- Reset mid-write: assert RST at cycle 3 of a 4-lane write of 0xDDCCBBAA to fresh words → lanes 0-1 written, lanes 2-3 unchanged. SP=0, RV=0, RD=0 the cycle after reset; the next request is accepted normally.
